// File: rtl/adder_rr_arbiter.sv
// Round-robin scheduler sharing one WIDTH-bit adder between N_REQ requesters, with a
// single-entry registered result buffer. Define ADDER_ARB_OVF_EN to add the res_ovf output.
module adder_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 64,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_cin,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_sum,
    output logic                   res_cout,
    output logic [ID_W-1:0]        res_id
`ifdef ADDER_ARB_OVF_EN
    ,
    output logic                   res_ovf
`endif
);

    // After reset the pointer sits on the last port, so requester 0 wins first.
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_sum_q, res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;

    logic             can_accept;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  cand;
    logic             accept;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_cin;
    logic [WIDTH:0]   sum_full;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // req_ready is one-hot on the granted, currently valid requester and never waits on
    // a future valid; a requester must hold valid and operands stable until accepted.
    assign can_accept = !res_valid_q || res_ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept = !rst && can_accept && grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_a    = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_b    = req_b[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_cin  = req_cin[grant_idx];
    assign sum_full = {1'b0, sel_a} + {1'b0, sel_b} + {{WIDTH{1'b0}}, sel_cin};

    // A drain and a new accept in the same cycle overwrite the buffer with no bubble.
    always_comb begin
        res_valid_d  = res_valid_q;
        res_sum_d    = res_sum_q;
        res_cout_d   = res_cout_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            res_valid_d  = 1'b1;
            res_sum_d    = sum_full[WIDTH-1:0];
            res_cout_d   = sum_full[WIDTH];
            res_id_d     = grant_idx;
            last_grant_d = grant_idx;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_sum_q    <= '0;
            res_cout_q   <= 1'b0;
            res_id_q     <= '0;
            last_grant_q <= LAST_RST;
        end else begin
            res_valid_q  <= res_valid_d;
            res_sum_q    <= res_sum_d;
            res_cout_q   <= res_cout_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;
    assign res_id    = res_id_q;

`ifdef ADDER_ARB_OVF_EN
    logic res_ovf_q, res_ovf_d;

    // Signed overflow: operands agree in sign but the sum does not.
    always_comb begin
        res_ovf_d = res_ovf_q;
        if (accept) begin
            res_ovf_d = (sel_a[WIDTH-1] == sel_b[WIDTH-1]) &&
                        (sum_full[WIDTH-1] != sel_a[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_ovf_q <= 1'b0;
        end else begin
            res_ovf_q <= res_ovf_d;
        end
    end

    assign res_ovf = res_ovf_q;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter (N_REQ=4, WIDTH=64); checks res_ovf
// as well when ADDER_ARB_OVF_EN is defined.
module tb_adder_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 64;
    localparam int IDW = 2;
    localparam int EW  = IDW + 1 + W;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_cin;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_sum;
    logic             res_cout;
    logic [IDW-1:0]   res_id;
`ifdef ADDER_ARB_OVF_EN
    logic             res_ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Expected results, {id, cout, sum}, in the order they should appear.
    logic [EW-1:0] exp_q[$];

    adder_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
`ifdef ADDER_ARB_OVF_EN
        ,
        .res_ovf   (res_ovf)
`endif
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
    endtask

    task automatic drive_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = cin;
        req_valid[i]    = 1'b1;
    endtask

    task automatic drive_all_four();
        drive_req(0, 64'h1000, 64'h20, 1'b0);
        drive_req(1, 64'h1001, 64'h20, 1'b1);
        drive_req(2, 64'h1002, 64'h20, 1'b0);
        drive_req(3, 64'h1003, 64'h20, 1'b1);
    endtask

    task automatic push_exp(input logic [IDW-1:0] id, input logic cout, input logic [W-1:0] sum);
        exp_q.push_back({id, cout, sum});
    endtask

    // Scoreboard: compare the buffered result against the oldest expectation.
    task automatic check_result(input string tag);
        logic [EW-1:0] e;
        check_eq({tag, "_valid"}, res_valid, 1'b1);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 1'b1, 1'b0);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, {res_id, res_cout, res_sum}, e);
        end
    endtask

    int grants [5] = '{1, 2, 3, 0, 1};
    logic [W-1:0] sums [4] = '{64'h1020, 64'h1022, 64'h1022, 64'h1024};

    initial begin
        rst       = 1'b1;
        res_ready = 1'b1;
        clear_reqs();
        tick();
        tick();

        // Reset state
        check_eq("rst_valid", res_valid, 1'b0);
        check_eq("rst_sum", res_sum, 64'h0);
        check_eq("rst_cout", res_cout, 1'b0);
        check_eq("rst_id", res_id, 2'd0);
`ifdef ADDER_ARB_OVF_EN
        check_eq("rst_ovf", res_ovf, 1'b0);
`endif
        req_valid = 4'hF;
        #1;
        check_eq("rst_ready_low", req_ready, 4'h0);

        // Single request with full carry-out
        rst = 1'b0;
        clear_reqs();
        drive_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        #1;
        check_eq("single_ready", req_ready, 4'b0001);
        push_exp(2'd0, 1'b1, 64'h0);
        tick();
        check_result("single_res");
`ifdef ADDER_ARB_OVF_EN
        check_eq("single_ovf", res_ovf, 1'b0);
`endif
        clear_reqs();
        tick();
        check_eq("drain_valid", res_valid, 1'b0);
        check_eq("drain_hold", {res_id, res_cout, res_sum}, {2'd0, 1'b1, 64'h0});

        // All four requesting continuously; pointer last granted 0
        drive_all_four();
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq($sformatf("rr_ready_%0d", k), req_ready, 4'b0001 << grants[k]);
            push_exp(IDW'(grants[k]), 1'b0, sums[grants[k]]);
            tick();
            check_result($sformatf("rr_res_%0d", k));
        end

        // Backpressure with all four still requesting
        res_ready = 1'b0;
        #1;
        check_eq("bp_ready0", req_ready, 4'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("bp_valid_%0d", k), res_valid, 1'b1);
            check_eq($sformatf("bp_hold_%0d", k), {res_id, res_sum}, {2'd1, 64'h1022});
            check_eq($sformatf("bp_ready_%0d", k), req_ready, 4'h0);
        end
        res_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", req_ready, 4'b0100);
        push_exp(2'd2, 1'b0, 64'h1022);
        tick();
        check_result("bp_release_res");

        // Carry-in path into the sign bit
        clear_reqs();
        drive_req(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        #1;
        check_eq("cin_ready", req_ready, 4'b0100);
        push_exp(2'd2, 1'b0, 64'h8000_0000_0000_0000);
        tick();
        check_result("cin_res");
`ifdef ADDER_ARB_OVF_EN
        check_eq("cin_ovf", res_ovf, 1'b1);
`endif

        // Wrap-around priority
        clear_reqs();
        drive_req(3, 64'h5, 64'h6, 1'b1);
        #1;
        check_eq("wrap_set_ready", req_ready, 4'b1000);
        push_exp(2'd3, 1'b0, 64'hC);
        tick();
        check_result("wrap_set_res");
        clear_reqs();
        drive_req(0, 64'h1000, 64'h20, 1'b0);
        drive_req(3, 64'h5, 64'h6, 1'b1);
        #1;
        check_eq("wrap_ready0", req_ready, 4'b0001);
        push_exp(2'd0, 1'b0, 64'h1020);
        tick();
        check_result("wrap_res0");
        #1;
        check_eq("wrap_ready3", req_ready, 4'b1000);
        push_exp(2'd3, 1'b0, 64'hC);
        tick();
        check_result("wrap_res3");

        // Reset mid-stream
        clear_reqs();
        drive_req(1, 64'h1001, 64'h20, 1'b1);
        #1;
        check_eq("mid_ready", req_ready, 4'b0010);
        push_exp(2'd1, 1'b0, 64'h1022);
        tick();
        check_result("mid_res");
        rst = 1'b1;
        drive_all_four();
        #1;
        check_eq("mid_rst_ready", req_ready, 4'h0);
        tick();
        check_eq("mid_rst_valid", res_valid, 1'b0);
        check_eq("mid_rst_sum", res_sum, 64'h0);
        check_eq("mid_rst_cout_id", {res_id, res_cout}, 3'b000);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", req_ready, 4'b0001);
        push_exp(2'd0, 1'b0, 64'h1020);
        tick();
        check_result("post_rst_res");
        clear_reqs();
        tick();
        check_eq("final_valid", res_valid, 1'b0);
        check_eq("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
